// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: ALU codes, datapath step
// states, instruction classes and the class decoder.
package proc_pkg;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_XOR  = 2'b10;
    localparam logic [1:0] ALU_SUB  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        T1,
        T2,
        T3
    } state_t;

    typedef enum logic [2:0] {
        LOAD,
        MOV,
        ALU,
        BRANCH,
        NOP
    } cls_t;

    // First match wins; illegal strobe mixes fall out by precedence.
    function automatic cls_t decode_cls(
        input logic branch,
        input logic ai,
        input logic gi,
        input logic go,
        input logic rxo,
        input logic ryi,
        input logic rxi
    );
        cls_t c;
        if (branch)
            c = BRANCH;
        else if (ai && gi && go)
            c = ALU;
        else if (rxo && ryi)
            c = MOV;
        else if (rxi)
            c = LOAD;
        else
            c = NOP;
        return c;
    endfunction

endpackage

// File: rtl/proc_datapath_if.sv
// Decoder-to-datapath instruction handshake: start, control strobes,
// register indices and immediate going in; busy/done coming back.
interface proc_datapath_if #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
);
    localparam int IDX_W = $clog2(NREG);

    logic              start;
    logic              rxi;
    logic              rxo;
    logic              ryi;
    logic              ryo;
    logic              ai;
    logic              gi;
    logic              go;
    logic              branch;
    logic [1:0]        alu;
    logic [IDX_W-1:0]  rx;
    logic [IDX_W-1:0]  ry;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;

    modport master (
        output start, rxi, rxo, ryi, ryo, ai, gi, go, branch,
        output alu, rx, ry, din,
        input  busy, done
    );

    modport slave (
        input  start, rxi, rxo, ryi, ryo, ai, gi, go, branch,
        input  alu, rx, ry, din,
        output busy, done
    );

endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: pass B, add, xor, subtract, all modulo 2^DATA_W.
// Ports: a, b operands; alu select code; y result.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        alu,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (alu)
            ALU_PASS: y = b;
            ALU_ADD:  y = a + b;
            ALU_XOR:  y = a ^ b;
            ALU_SUB:  y = a - b;
        endcase
    end

endmodule

// File: rtl/proc_datapath.sv
// Sequenced datapath: captures one instruction on start, then runs it as
// up to three bus steps through the register file, A, ALU and G latches.
// Ports: clk, rst (sync, active high); io (slave side of the instruction
// handshake); bus, pc observation; dbg_sel/dbg_data register read port.
module proc_datapath
    import proc_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NREG   = 4,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    proc_datapath_if.slave    io,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] pc,
    input  logic [IDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    state_t            state_n;
    cls_t              cls_q;
    logic [1:0]        alu_q;
    logic [IDX_W-1:0]  rx_q;
    logic [IDX_W-1:0]  ry_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] g_q;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] regs [NREG];

    logic              done_c;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              a_en;
    logic              g_en;
    logic              accept;

    // ryo carries no information for class decode; MOV is keyed on rxo/ryi.
    logic              ryo_unused;
    assign ryo_unused = io.ryo;

    assign accept   = (state == IDLE) && io.start;
    assign io.busy  = (state != IDLE);
    assign io.done  = done_c;
    assign dbg_data = regs[dbg_sel];

    proc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a   (a_q),
        .b   (bus),
        .alu (alu_q),
        .y   (alu_y)
    );

    always_comb begin
        state_n = state;
        bus     = '0;
        done_c  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = rx_q;
        a_en    = 1'b0;
        g_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (io.start)
                    state_n = T1;
            end
            T1: begin
                case (cls_q)
                    LOAD: begin
                        bus   = din_q;
                        wr_en = 1'b1;
                    end
                    MOV: begin
                        bus    = regs[rx_q];
                        wr_en  = 1'b1;
                        wr_idx = ry_q;
                    end
                    BRANCH: bus = din_q;
                    ALU: begin
                        bus  = regs[rx_q];
                        a_en = 1'b1;
                    end
                    default: bus = '0;
                endcase
                if (cls_q == ALU) begin
                    state_n = T2;
                end else begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            T2: begin
                bus     = regs[ry_q];
                g_en    = 1'b1;
                state_n = T3;
            end
            T3: begin
                bus     = g_q;
                wr_en   = 1'b1;
                done_c  = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cls_q <= NOP;
            alu_q <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
            din_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cls_q <= decode_cls(io.branch, io.ai, io.gi, io.go,
                                    io.rxo, io.ryi, io.rxi);
                alu_q <= io.alu;
                rx_q  <= io.rx;
                ry_q  <= io.ry;
                din_q <= io.din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            g_q <= '0;
            pc  <= '0;
        end else begin
            if (a_en)
                a_q <= bus;
            if (g_en)
                g_q <= alu_y;
            if (done_c)
                pc <= (cls_q == BRANCH) ? bus : pc + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= bus;
        end
    end

endmodule

// File: tb/tb_proc_datapath.sv
// Directed bench for proc_datapath: expected bus values queued at issue,
// popped and compared on done; state checked via pc and dbg_data.
module tb_proc_datapath;

    localparam int DATA_W = 8;
    localparam int NREG   = 4;

    localparam logic [7:0] F_RXI = 8'h80;
    localparam logic [7:0] F_RXO = 8'h40;
    localparam logic [7:0] F_RYI = 8'h20;
    localparam logic [7:0] F_RYO = 8'h10;
    localparam logic [7:0] F_AI  = 8'h08;
    localparam logic [7:0] F_GI  = 8'h04;
    localparam logic [7:0] F_GO  = 8'h02;
    localparam logic [7:0] F_BR  = 8'h01;
    localparam logic [7:0] F_ALU = F_RXO | F_RYO | F_AI | F_GI | F_GO;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bus;
    logic [7:0]  pc;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb [$];
    logic [7:0]  exp_pc;

    proc_datapath_if #(.DATA_W(DATA_W), .NREG(NREG)) ifc ();

    proc_datapath #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (ifc.slave),
        .bus      (bus),
        .pc       (pc),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] f, input logic [1:0] a,
                         input logic [1:0] x, input logic [1:0] y,
                         input logic [7:0] d);
        {ifc.rxi, ifc.rxo, ifc.ryi, ifc.ryo,
         ifc.ai, ifc.gi, ifc.go, ifc.branch} = f;
        ifc.alu = a;
        ifc.rx  = x;
        ifc.ry  = y;
        ifc.din = d;
    endtask

    // Pop the next expected bus value and compare to the live bus.
    task automatic sb_pop(input string tag);
        logic [7:0] e;
        check({tag, "_sb_avail"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_bus"}, bus, e);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (ifc.done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_done"}, ifc.done, 1);
        sb_pop(tag);
    endtask

    task automatic reg_is(input string tag, input logic [1:0] idx,
                          input logic [7:0] v);
        dbg_sel = idx;
        #1;
        check(tag, dbg_data, v);
    endtask

    // Single-step instruction: issue, expect done in T1, then settle.
    task automatic one_step(input string tag, input logic [7:0] f,
                            input logic [1:0] x, input logic [1:0] y,
                            input logic [7:0] d, input logic [7:0] eb);
        drive(f, 2'b00, x, y, d);
        ifc.start = 1'b1;
        sb.push_back(eb);
        tick();
        ifc.start = 1'b0;
        drive(8'h00, 2'b00, 2'd0, 2'd0, 8'hFF);
        check({tag, "_latency"}, ifc.done, 1);
        wait_done(tag);
        tick();
        check({tag, "_busy_after"}, ifc.busy, 0);
    endtask

    initial begin
        ifc.start = 1'b0;
        drive(8'h00, 2'b00, 2'd0, 2'd0, 8'h00);
        exp_pc = 8'h00;

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_pc", pc, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        check("rst_bus", bus, 0);
        for (int i = 0; i < NREG; i++)
            reg_is("rst_reg", 2'(i), 8'h00);

        one_step("load", F_RXI, 2'd2, 2'd0, 8'h5A, 8'h5A);
        exp_pc++;
        reg_is("load_r2", 2'd2, 8'h5A);
        check("load_pc", pc, exp_pc);

        one_step("ld_r1", F_RXI, 2'd1, 2'd0, 8'hF0, 8'hF0);
        one_step("ld_r2", F_RXI, 2'd2, 2'd0, 8'h20, 8'h20);
        exp_pc += 2;

        // ALU add with rxi also set: ALU outranks LOAD.
        drive(F_ALU | F_RXI, 2'b01, 2'd1, 2'd2, 8'h77);
        ifc.start = 1'b1;
        sb.push_back(8'hF0);
        sb.push_back(8'h20);
        sb.push_back(8'h10);
        tick();
        ifc.start = 1'b0;
        check("add_t1_done", ifc.done, 0);
        sb_pop("add_t1");
        tick();
        check("add_t2_done", ifc.done, 0);
        sb_pop("add_t2");
        tick();
        check("add_t3_done", ifc.done, 1);
        sb_pop("add_t3");
        tick();
        exp_pc++;
        reg_is("add_r1", 2'd1, 8'h10);
        reg_is("add_r2", 2'd2, 8'h20);
        check("add_pc", pc, exp_pc);

        one_step("ld_r3", F_RXI, 2'd3, 2'd0, 8'hAA, 8'hAA);
        exp_pc++;

        // Xor self; a start pulse in T2 must be ignored.
        drive(F_ALU, 2'b10, 2'd3, 2'd3, 8'h00);
        ifc.start = 1'b1;
        sb.push_back(8'hAA);
        sb.push_back(8'hAA);
        sb.push_back(8'h00);
        tick();
        ifc.start = 1'b0;
        sb_pop("xor_t1");
        tick();
        sb_pop("xor_t2");
        drive(F_RXI, 2'b00, 2'd0, 2'd0, 8'h99);
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        check("xor_t3_done", ifc.done, 1);
        sb_pop("xor_t3");
        tick();
        exp_pc++;
        check("xor_idle_done", ifc.done, 0);
        check("xor_idle_busy", ifc.busy, 0);
        tick();
        check("xor_no_2nd_done", ifc.done, 0);
        reg_is("xor_r3", 2'd3, 8'h00);
        reg_is("xor_r0_kept", 2'd0, 8'h00);
        check("xor_pc", pc, exp_pc);

        // Branch with rxi set: branch wins, no register write.
        one_step("branch", F_BR | F_RXI, 2'd0, 2'd0, 8'h40, 8'h40);
        exp_pc = 8'h40;
        check("branch_pc", pc, exp_pc);
        reg_is("branch_r0", 2'd0, 8'h00);

        // Reset during T2 of an ALU op.
        drive(F_ALU, 2'b01, 2'd1, 2'd2, 8'h00);
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        check("mid_t2_busy", ifc.busy, 1);
        check("mid_t2_done", ifc.done, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", ifc.busy, 0);
        check("mid_done", ifc.done, 0);
        check("mid_bus", bus, 0);
        check("mid_pc", pc, 0);
        for (int i = 0; i < NREG; i++)
            reg_is("mid_reg", 2'(i), 8'h00);
        tick();
        check("mid_no_done", ifc.done, 0);
        exp_pc = 8'h00;

        one_step("post_ld", F_RXI, 2'd0, 2'd0, 8'h33, 8'h33);
        exp_pc++;
        reg_is("post_r0", 2'd0, 8'h33);
        check("post_pc", pc, exp_pc);

        one_step("mov", F_RXO | F_RYI, 2'd0, 2'd1, 8'hEE, 8'h33);
        exp_pc++;
        reg_is("mov_r1", 2'd1, 8'h33);
        check("mov_pc", pc, exp_pc);

        one_step("nop", 8'h00, 2'd2, 2'd3, 8'hEE, 8'h00);
        exp_pc++;
        check("nop_pc", pc, exp_pc);
        reg_is("nop_r2", 2'd2, 8'h00);

        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
